// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-M up/down counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned SAT_WRAP = 0;
    localparam int unsigned SAT_HOLD = 1;

    // Bits needed to hold value-1; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_mod_m_next.sv
// Combinational next-state, terminal-count and wrap detection for the modulo-M counter.
module counter_mod_m_next
    import counter_pkg::*;
#(
    parameter int unsigned M   = 20,
    parameter int unsigned SAT = SAT_WRAP,
    localparam int unsigned N  = (clog2(M) < 1) ? 1 : clog2(M)
) (
    input  logic [N-1:0] q_i,
    input  logic         up_i,
    input  logic         enable_i,
    input  logic         load_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_next_o,
    output logic         tc_o,
    output logic         wrap_o
);

    localparam logic [N-1:0] QMax = N'(M - 1);

    logic at_bound;
    logic [N-1:0] step_q;

    always_comb begin
        at_bound = 1'b0;
        step_q   = q_i;
        unique case (up_i)
            DIR_UP: begin
                at_bound = (q_i == QMax);
                if (at_bound) begin
                    step_q = (SAT == SAT_HOLD) ? QMax : '0;
                end else begin
                    step_q = q_i + N'(1);
                end
            end
            DIR_DOWN: begin
                at_bound = (q_i == '0);
                if (at_bound) begin
                    step_q = (SAT == SAT_HOLD) ? '0 : QMax;
                end else begin
                    step_q = q_i - N'(1);
                end
            end
            default: begin
                at_bound = 1'b0;
                step_q   = q_i;
            end
        endcase
    end

    always_comb begin
        q_next_o = q_i;
        if (load_i) begin
            // Out-of-range load values clamp to the top of the range.
            q_next_o = (d_i > QMax) ? QMax : d_i;
        end else if (enable_i) begin
            q_next_o = step_q;
        end
    end

    assign tc_o   = enable_i & ~load_i & at_bound;
    assign wrap_o = tc_o & (SAT == SAT_WRAP);

endmodule

// File: rtl/counter_mod_m_updown.sv
// Modulo-M up/down counter with load, saturate/wrap mode, cascade tc and rollover pulse.
// Optional rollover event counter on port wraps when COUNTER_WRAPCNT_EN is defined.
module counter_mod_m_updown
    import counter_pkg::*;
#(
    parameter int unsigned M   = 20,
    parameter int unsigned SAT = SAT_WRAP,
    parameter int unsigned W   = 8,
    localparam int unsigned N  = (clog2(M) < 1) ? 1 : clog2(M)
) (
    input  logic         clk,
    input  logic         sclr,
    input  logic         enable,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] Q,
    output logic         tc,
`ifdef COUNTER_WRAPCNT_EN
    output logic [W-1:0] wraps,
`endif
    output logic         rollover
);

    if (M < 2) begin : g_bad_m
        $error("counter_mod_m_updown: M must be >= 2");
    end
    if (W < 1) begin : g_bad_w
        $error("counter_mod_m_updown: W must be >= 1");
    end

    logic [N-1:0] q_d, q_q, q_next;
    logic         rollover_d, rollover_q;
    logic         wrap;

    counter_mod_m_next #(
        .M   (M),
        .SAT (SAT)
    ) u_next (
        .q_i      (q_q),
        .up_i     (up),
        .enable_i (enable),
        .load_i   (load),
        .d_i      (d),
        .q_next_o (q_next),
        .tc_o     (tc),
        .wrap_o   (wrap)
    );

    always_comb begin
        q_d        = q_next;
        rollover_d = wrap;
        if (sclr) begin
            q_d        = '0;
            rollover_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        q_q        <= q_d;
        rollover_q <= rollover_d;
    end

    assign Q        = q_q;
    assign rollover = rollover_q;

`ifdef COUNTER_WRAPCNT_EN
    logic [W-1:0] wraps_d, wraps_q;

    always_comb begin
        wraps_d = wraps_q;
        if (sclr) begin
            wraps_d = '0;
        end else if (wrap && (wraps_q != {W{1'b1}})) begin
            wraps_d = wraps_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        wraps_q <= wraps_d;
    end

    assign wraps = wraps_q;
`endif

endmodule

// File: tb/tb_counter_mod_m_updown.sv
// Directed self-checking bench for counter_mod_m_updown (several parameterisations + cascade).
module tb_counter_mod_m_updown;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // M=5, wrap
    logic       sclr5, en5, up5, ld5, tc5, ro5;
    logic [2:0] d5, q5;
    // M=6, saturate
    logic       sclr6, en6, up6, ld6, tc6, ro6;
    logic [2:0] d6, q6;
    // M=10, wrap
    logic       sclr10, en10, up10, ld10, tc10, ro10;
    logic [3:0] d10, q10;
    // Cascade of two M=10 stages
    logic       sclr_c, en_c, tc_c0, tc_c1, ro_c0, ro_c1;
    logic [3:0] q_c0, q_c1;
    logic [3:0] d_zero = 4'd0;
`ifdef COUNTER_WRAPCNT_EN
    logic [7:0] wr5, wr6, wr10, wr_c0, wr_c1;
`endif

    counter_mod_m_updown #(.M(5), .SAT(0), .W(8)) u5 (
        .clk(clk), .sclr(sclr5), .enable(en5), .up(up5), .load(ld5), .d(d5),
        .Q(q5), .tc(tc5),
`ifdef COUNTER_WRAPCNT_EN
        .wraps(wr5),
`endif
        .rollover(ro5)
    );

    counter_mod_m_updown #(.M(6), .SAT(1), .W(8)) u6 (
        .clk(clk), .sclr(sclr6), .enable(en6), .up(up6), .load(ld6), .d(d6),
        .Q(q6), .tc(tc6),
`ifdef COUNTER_WRAPCNT_EN
        .wraps(wr6),
`endif
        .rollover(ro6)
    );

    counter_mod_m_updown #(.M(10), .SAT(0), .W(8)) u10 (
        .clk(clk), .sclr(sclr10), .enable(en10), .up(up10), .load(ld10), .d(d10),
        .Q(q10), .tc(tc10),
`ifdef COUNTER_WRAPCNT_EN
        .wraps(wr10),
`endif
        .rollover(ro10)
    );

    counter_mod_m_updown #(.M(10), .SAT(0), .W(8)) u_c0 (
        .clk(clk), .sclr(sclr_c), .enable(en_c), .up(1'b1), .load(1'b0), .d(d_zero),
        .Q(q_c0), .tc(tc_c0),
`ifdef COUNTER_WRAPCNT_EN
        .wraps(wr_c0),
`endif
        .rollover(ro_c0)
    );

    counter_mod_m_updown #(.M(10), .SAT(0), .W(8)) u_c1 (
        .clk(clk), .sclr(sclr_c), .enable(tc_c0), .up(1'b1), .load(1'b0), .d(d_zero),
        .Q(q_c1), .tc(tc_c1),
`ifdef COUNTER_WRAPCNT_EN
        .wraps(wr_c1),
`endif
        .rollover(ro_c1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sclr5 = 1; en5 = 1; up5 = 1; ld5 = 1; d5 = 3'd3;
        sclr6 = 1; en6 = 1; up6 = 1; ld6 = 1; d6 = 3'd3;
        sclr10 = 1; en10 = 1; up10 = 1; ld10 = 1; d10 = 4'd3;
        sclr_c = 1; en_c = 1;
        tick();
        n_checks++;
        if (q5 !== 3'd0) begin
            n_fail++; $display("FAIL reset_q5: got %0d expected 0", q5);
        end
        n_checks++;
        if (ro5 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ro5: got %b expected 0", ro5);
        end
        n_checks++;
        if (q6 !== 3'd0 || q10 !== 4'd0) begin
            n_fail++; $display("FAIL reset_q6_q10: got %0d/%0d expected 0/0", q6, q10);
        end
        n_checks++;
        if (q_c0 !== 4'd0 || q_c1 !== 4'd0) begin
            n_fail++; $display("FAIL reset_cascade: got %0d/%0d expected 0/0", q_c1, q_c0);
        end
`ifdef COUNTER_WRAPCNT_EN
        n_checks++;
        if (wr5 !== 8'd0) begin
            n_fail++; $display("FAIL reset_wraps5: got %0d expected 0", wr5);
        end
`endif
        sclr5 = 0; ld5 = 0; en5 = 0;
        sclr6 = 0; ld6 = 0; en6 = 0;
        sclr10 = 0; ld10 = 0; en10 = 0;
        en_c = 0;
    endtask

    task automatic test_up_wrap();
        logic [2:0] exp_q  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        logic       exp_tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_ro [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        en5 = 1; up5 = 1; ld5 = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (tc5 !== exp_tc[i]) begin
                n_fail++; $display("FAIL up_wrap_tc[%0d]: got %b expected %b", i, tc5, exp_tc[i]);
            end
            tick();
            n_checks++;
            if (q5 !== exp_q[i] || ro5 !== exp_ro[i]) begin
                n_fail++;
                $display("FAIL up_wrap_q[%0d]: got q=%0d ro=%b expected q=%0d ro=%b",
                         i, q5, ro5, exp_q[i], exp_ro[i]);
            end
        end
`ifdef COUNTER_WRAPCNT_EN
        n_checks++;
        if (wr5 !== 8'd1) begin
            n_fail++; $display("FAIL up_wrap_wraps: got %0d expected 1", wr5);
        end
`endif
        en5 = 0;
    endtask

    task automatic test_down_sat();
        logic [2:0] exp_q  [4] = '{3'd1, 3'd0, 3'd0, 3'd0};
        logic       exp_tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        ld6 = 1; d6 = 3'd2; en6 = 1; up6 = 0;
        tick();
        n_checks++;
        if (q6 !== 3'd2) begin
            n_fail++; $display("FAIL down_sat_load: got %0d expected 2", q6);
        end
        ld6 = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (tc6 !== exp_tc[i]) begin
                n_fail++; $display("FAIL down_sat_tc[%0d]: got %b expected %b", i, tc6, exp_tc[i]);
            end
            tick();
            n_checks++;
            if (q6 !== exp_q[i] || ro6 !== 1'b0) begin
                n_fail++;
                $display("FAIL down_sat_q[%0d]: got q=%0d ro=%b expected q=%0d ro=0",
                         i, q6, ro6, exp_q[i]);
            end
        end
        en6 = 0;
    endtask

    task automatic test_load_clamp();
        ld10 = 1; d10 = 4'd13; en10 = 1; up10 = 1;
        #1;
        n_checks++;
        if (tc10 !== 1'b0) begin
            n_fail++; $display("FAIL clamp_tc_during_load: got %b expected 0", tc10);
        end
        tick();
        n_checks++;
        if (q10 !== 4'd9 || ro10 !== 1'b0) begin
            n_fail++; $display("FAIL clamp_q: got q=%0d ro=%b expected q=9 ro=0", q10, ro10);
        end
        ld10 = 0;
        #1;
        n_checks++;
        if (tc10 !== 1'b1) begin
            n_fail++; $display("FAIL clamp_tc_at_top: got %b expected 1", tc10);
        end
        tick();
        n_checks++;
        if (q10 !== 4'd0 || ro10 !== 1'b1) begin
            n_fail++; $display("FAIL clamp_wrap: got q=%0d ro=%b expected q=0 ro=1", q10, ro10);
        end
        en10 = 0;
        tick();
        n_checks++;
        if (q10 !== 4'd0 || ro10 !== 1'b0) begin
            n_fail++; $display("FAIL clamp_pulse_end: got q=%0d ro=%b expected q=0 ro=0", q10, ro10);
        end
    endtask

    task automatic test_direction();
        // Down-wrap from 0, then immediately back up across the bound.
        en10 = 1; up10 = 0;
        tick();
        n_checks++;
        if (q10 !== 4'd9 || ro10 !== 1'b1) begin
            n_fail++; $display("FAIL dir_down_wrap: got q=%0d ro=%b expected q=9 ro=1", q10, ro10);
        end
        up10 = 1;
        tick();
        n_checks++;
        if (q10 !== 4'd0 || ro10 !== 1'b1) begin
            n_fail++; $display("FAIL dir_up_wrap: got q=%0d ro=%b expected q=0 ro=1", q10, ro10);
        end
        tick();
        n_checks++;
        if (q10 !== 4'd1 || ro10 !== 1'b0) begin
            n_fail++; $display("FAIL dir_up_step: got q=%0d ro=%b expected q=1 ro=0", q10, ro10);
        end
        en10 = 0;
    endtask

    task automatic test_enable_gating();
        ld5 = 1; d5 = 3'd4; en5 = 0;
        tick();
        ld5 = 0; up5 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (tc5 !== 1'b0) begin
                n_fail++; $display("FAIL gate_tc[%0d]: got %b expected 0", i, tc5);
            end
            tick();
            n_checks++;
            if (q5 !== 3'd4 || ro5 !== 1'b0) begin
                n_fail++; $display("FAIL gate_q[%0d]: got q=%0d ro=%b expected q=4 ro=0", i, q5, ro5);
            end
        end
    endtask

    task automatic test_cascade();
        sclr_c = 1; en_c = 0;
        tick();
        sclr_c = 0; en_c = 1;
        for (int i = 0; i < 137; i++) tick();
        en_c = 0;
        n_checks++;
        if (q_c1 !== 4'd3 || q_c0 !== 4'd7) begin
            n_fail++; $display("FAIL cascade: got %0d%0d expected 37", q_c1, q_c0);
        end
        tick();
        n_checks++;
        if (q_c1 !== 4'd3 || q_c0 !== 4'd7) begin
            n_fail++; $display("FAIL cascade_hold: got %0d%0d expected 37", q_c1, q_c0);
        end
    endtask

    initial begin
        sclr5 = 1; en5 = 0; up5 = 1; ld5 = 0; d5 = '0;
        sclr6 = 1; en6 = 0; up6 = 1; ld6 = 0; d6 = '0;
        sclr10 = 1; en10 = 0; up10 = 1; ld10 = 0; d10 = '0;
        sclr_c = 1; en_c = 0;
        tick();
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_load_clamp();
        test_direction();
        test_enable_gating();
        test_cascade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
